// File: rtl/izh_pkg.sv
// izh_pkg: shared types and constants for the Izhikevich neuron array.
//   state_t  - sweep FSM states (IDLE, RUN, DONE)
//   IZH_*    - fixed datapath constants of the fixed-point v update
//   sat()    - clamps a wide signed value to the signed range of w bits
package izh_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic signed [127:0] wide_t;

  localparam int IZH_K1400    = 1400;
  localparam int IZH_VV_SHIFT = 8;
  localparam int IZH_MUL6     = 6;

  // The caller narrows the result with a size cast; w must be <= 127.
  function automatic wide_t sat(input wide_t x, input int w);
    wide_t hi, lo, r;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    r  = x;
    if (x > hi) r = hi;
    else if (x < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/izh_neuron_array_if.sv
// izh_neuron_array_if: control / debug bus of the neuron array.
//   step_i, i_in, rd_idx        driven by the stimulus side (master)
//   busy_o, done_o, spike_o,
//   rd_v, rd_u                  driven by the array (slave)
// With IZH_SPIKE_COUNT_EN defined the bus also carries clr_cnt_i (master)
// and rd_cnt (slave).
interface izh_neuron_array_if #(
  parameter int N_NEURONS = 4,
  parameter int I_W       = 11,
  parameter int V_W       = 32,
  parameter int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);
  logic                        step_i;
  logic [N_NEURONS*I_W-1:0]    i_in;
  logic                        busy_o;
  logic                        done_o;
  logic [N_NEURONS-1:0]        spike_o;
  logic [IDX_W-1:0]            rd_idx;
  logic signed [V_W-1:0]       rd_v;
  logic signed [V_W-1:0]       rd_u;
`ifdef IZH_SPIKE_COUNT_EN
  logic                        clr_cnt_i;
  logic [15:0]                 rd_cnt;

  modport master (output step_i, i_in, rd_idx, clr_cnt_i,
                  input  busy_o, done_o, spike_o, rd_v, rd_u, rd_cnt);
  modport slave  (input  step_i, i_in, rd_idx, clr_cnt_i,
                  output busy_o, done_o, spike_o, rd_v, rd_u, rd_cnt);
`else
  modport master (output step_i, i_in, rd_idx,
                  input  busy_o, done_o, spike_o, rd_v, rd_u);
  modport slave  (input  step_i, i_in, rd_idx,
                  output busy_o, done_o, spike_o, rd_v, rd_u);
`endif
endinterface

// File: rtl/izh_update_core.sv
// izh_update_core: combinational single-neuron Izhikevich step.
//   v, u     in   current state (signed V_W)
//   i_cur    in   input current (signed I_W)
//   v_next   out  next v (C_RESET on spike, else saturated v_int)
//   u_next   out  next u (saturated, D_INC added on spike)
//   spike    out  v_int > THRESHOLD
// All arithmetic runs at 2*V_W bits so v*v cannot overflow before the clamp.
module izh_update_core
  import izh_pkg::*;
#(
  parameter int V_W       = 32,
  parameter int I_W       = 11,
  parameter int THRESHOLD = 300,
  parameter int C_RESET   = -650,
  parameter int D_INC     = 80,
  parameter int A_SHIFT   = 6,
  parameter int B_NUM     = 13,
  parameter int B_SHIFT   = 6
) (
  input  logic signed [V_W-1:0] v,
  input  logic signed [V_W-1:0] u,
  input  logic signed [I_W-1:0] i_cur,
  output logic signed [V_W-1:0] v_next,
  output logic signed [V_W-1:0] u_next,
  output logic                  spike
);
  localparam int W2 = 2 * V_W;
  typedef logic signed [W2-1:0] w2_t;

  w2_t   v_x, u_x, i_x, v_int, u_upd, u_new;
  wide_t v_sat, u_sat;

  always_comb begin
    v_x   = w2_t'(v);
    u_x   = w2_t'(u);
    i_x   = w2_t'(i_cur);
    v_int = ((v_x * v_x) >>> IZH_VV_SHIFT) + w2_t'(IZH_MUL6) * v_x
            + w2_t'(IZH_K1400) - u_x + i_x;
    spike = v_int > w2_t'(THRESHOLD);
    // u += a*(b*v - u), with a and b as power-of-two fractions
    u_upd = u_x + ((((w2_t'(B_NUM) * v_x) >>> B_SHIFT) - u_x) >>> A_SHIFT);
    u_new = spike ? u_upd + w2_t'(D_INC) : u_upd;
    v_sat = sat(wide_t'(v_int), V_W);
    u_sat = sat(wide_t'(u_new), V_W);
    v_next = spike ? V_W'(C_RESET) : V_W'(v_sat);
    u_next = V_W'(u_sat);
  end

endmodule

// File: rtl/izh_neuron_array.sv
// izh_neuron_array: N Izhikevich neurons sharing one update datapath.
//   clk, rst  clock / synchronous active-high reset
//   bus       izh_neuron_array_if.slave: step_i starts a sweep (IDLE only),
//             i_in latched on acceptance, busy_o/done_o/spike_o status,
//             rd_idx/rd_v/rd_u combinational debug read of the state regs.
// A sweep updates neuron idx=0..N-1, one per cycle, then spends one cycle
// in DONE where done_o pulses and spike_o takes the gathered flags.
// Optional feature macro IZH_SPIKE_COUNT_EN: per-neuron saturating 16-bit
// spike counters, cleared by clr_cnt_i, read as rd_cnt[rd_idx].
module izh_neuron_array
  import izh_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int V_W       = 32,
  parameter int I_W       = 11,
  parameter int THRESHOLD = 300,
  parameter int C_RESET   = -650,
  parameter int D_INC     = 80,
  parameter int U_INIT    = -130,
  parameter int A_SHIFT   = 6,
  parameter int B_NUM     = 13,
  parameter int B_SHIFT   = 6
) (
  input logic               clk,
  input logic               rst,
  izh_neuron_array_if.slave bus
);
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [N_NEURONS-1:0][I_W-1:0]   i_lat;
  logic signed [V_W-1:0]           v_mem [N_NEURONS];
  logic signed [V_W-1:0]           u_mem [N_NEURONS];
  logic [N_NEURONS-1:0]            shadow, shadow_nxt, spike_q;
  logic                            busy_q, done_q;

  logic signed [V_W-1:0]           v_next, u_next;
  logic                            spike;

  izh_update_core #(
    .V_W(V_W), .I_W(I_W), .THRESHOLD(THRESHOLD), .C_RESET(C_RESET),
    .D_INC(D_INC), .A_SHIFT(A_SHIFT), .B_NUM(B_NUM), .B_SHIFT(B_SHIFT)
  ) u_core (
    .v(v_mem[idx]), .u(u_mem[idx]), .i_cur(i_lat[idx]),
    .v_next(v_next), .u_next(u_next), .spike(spike)
  );

  // include the neuron being updated this cycle so DONE sees all N flags
  assign shadow_nxt = shadow | (spike ? (N_NEURONS'(1) << idx) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      i_lat   <= '0;
      shadow  <= '0;
      spike_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= V_W'(C_RESET);
        u_mem[k] <= V_W'(U_INIT);
      end
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.step_i) begin
            state  <= RUN;
            busy_q <= 1'b1;
            idx    <= '0;
            shadow <= '0;
            i_lat  <= bus.i_in;
          end
        end
        RUN: begin
          v_mem[idx] <= v_next;
          u_mem[idx] <= u_next;
          shadow     <= shadow_nxt;
          if (idx == LAST) begin
            state   <= DONE;
            done_q  <= 1'b1;
            spike_q <= shadow_nxt;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.spike_o = spike_q;
  assign bus.rd_v    = v_mem[bus.rd_idx];
  assign bus.rd_u    = u_mem[bus.rd_idx];

`ifdef IZH_SPIKE_COUNT_EN
  logic [15:0] cnt [N_NEURONS];

  // clear has priority, so a clear coinciding with a spike leaves 0
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt_i) begin
      for (int k = 0; k < N_NEURONS; k++) cnt[k] <= '0;
    end else if (state == RUN && spike && cnt[idx] != 16'hFFFF) begin
      cnt[idx] <= cnt[idx] + 16'd1;
    end
  end

  assign bus.rd_cnt = cnt[bus.rd_idx];
`endif

endmodule

// File: tb/tb_izh_neuron_array.sv
module tb_izh_neuron_array;
  localparam int N  = 4;
  localparam int IW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  izh_neuron_array_if #(.N_NEURONS(N), .I_W(IW), .V_W(32)) bus ();

  izh_neuron_array #(.N_NEURONS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit              do_rst;
    logic [N*IW-1:0] i;
    int              ev [N];
    int              eu [N];
    logic [N-1:0]    esp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [N*IW-1:0] pack(input int a, input int b,
                                           input int c, input int d);
    logic [31:0] ta, tb, tc, td;
    ta = a; tb = b; tc = c; td = d;
    return {td[IW-1:0], tc[IW-1:0], tb[IW-1:0], ta[IW-1:0]};
  endfunction

  task automatic set_vec(input int n, input bit r, input logic [N*IW-1:0] i,
                         input int v0, input int v1, input int v2, input int v3,
                         input int u0, input int u1, input int u2, input int u3,
                         input logic [N-1:0] sp);
    vecs[n].do_rst = r;
    vecs[n].i      = i;
    vecs[n].ev[0] = v0; vecs[n].ev[1] = v1; vecs[n].ev[2] = v2; vecs[n].ev[3] = v3;
    vecs[n].eu[0] = u0; vecs[n].eu[1] = u1; vecs[n].eu[2] = u2; vecs[n].eu[3] = u3;
    vecs[n].esp    = sp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int v0, input int v1,
                           input int v2, input int v3, input int u0,
                           input int u1, input int u2, input int u3);
    int ev [N];
    int eu [N];
    ev[0] = v0; ev[1] = v1; ev[2] = v2; ev[3] = v3;
    eu[0] = u0; eu[1] = u1; eu[2] = u2; eu[3] = u3;
    for (int k = 0; k < N; k++) begin
      bus.rd_idx = k[1:0];
      #0.1;
      chk($sformatf("%s v[%0d]", tag, k), bus.rd_v, ev[k]);
      chk($sformatf("%s u[%0d]", tag, k), bus.rd_u, eu[k]);
    end
  endtask

  initial begin
    int lat, ndone, done_at;
    logic [N-1:0] prev_sp;

    bus.step_i = 1'b0;
    bus.i_in   = '0;
    bus.rd_idx = '0;
`ifdef IZH_SPIKE_COUNT_EN
    bus.clr_cnt_i = 1'b0;
`endif

    // inputs, then expected v[0..3], u[0..3], spike_o after one sweep
    set_vec(0, 1, pack(0, 0, 0, 0),
            -720, -720, -720, -720, -131, -131, -131, -131, 4'b0000);
    set_vec(1, 0, pack(0, 0, 0, 0),
            -764, -764, -764, -764, -132, -132, -132, -132, 4'b0000);
    set_vec(2, 1, pack(0, 0, 1023, 0),
            -720, -720, -650, -720, -131, -131, -51, -131, 4'b0100);
    set_vec(3, 0, pack(0, 0, 0, 0),
            -764, -764, -799, -764, -132, -132, -53, -132, 4'b0000);
    set_vec(4, 1, pack(-1024, -1024, -1024, -1024),
            -1744, -1744, -1744, -1744, -131, -131, -131, -131, 4'b0000);
    set_vec(5, 1, pack(1023, 0, 0, 900),
            -650, -720, -720, 180, -51, -131, -131, -131, 4'b0001);
    set_vec(6, 0, pack(0, 0, 0, 0),
            -799, -764, -764, -650, -53, -132, -132, -49, 4'b1000);

    // reset state
    tick();
    do_reset();
    chk_state("reset", -650, -650, -650, -650, -130, -130, -130, -130);
    chk("reset busy", bus.busy_o, 0);
    chk("reset done", bus.done_o, 0);
    chk("reset spike", bus.spike_o, 0);

    // table-driven sweeps
    prev_sp = '0;
    for (int n = 0; n < 7; n++) begin
      if (vecs[n].do_rst) begin
        do_reset();
        prev_sp = '0;
      end
      bus.i_in   = vecs[n].i;
      bus.step_i = 1'b1;
      tick();
      bus.step_i = 1'b0;
      bus.i_in   = '0;
      lat = 1;
      while (!bus.done_o && lat < 20) begin
        if (lat == 2)
          chk($sformatf("vec%0d spike held mid-sweep", n), bus.spike_o, prev_sp);
        tick();
        lat++;
      end
      chk($sformatf("vec%0d done latency", n), lat, N + 1);
      chk($sformatf("vec%0d spike", n), bus.spike_o, vecs[n].esp);
      tick();
      chk_state($sformatf("vec%0d", n), vecs[n].ev[0], vecs[n].ev[1],
                vecs[n].ev[2], vecs[n].ev[3], vecs[n].eu[0], vecs[n].eu[1],
                vecs[n].eu[2], vecs[n].eu[3]);
      prev_sp = vecs[n].esp;
    end

    // step re-pulsed at +1..+4 of a sweep is ignored
    do_reset();
    ndone = 0;
    done_at = 0;
    bus.step_i = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 5) bus.step_i = 1'b0;
      if (bus.done_o) begin
        ndone++;
        if (done_at == 0) done_at = c;
      end
    end
    bus.step_i = 1'b0;
    chk("repulse done count", ndone, 1);
    chk("repulse done cycle", done_at, N + 1);
    chk_state("repulse", -720, -720, -720, -720, -131, -131, -131, -131);

    // rst on the 3rd RUN cycle aborts the sweep
    do_reset();
    ndone = 0;
    bus.i_in = pack(1023, 1023, 1023, 1023);
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    if (bus.done_o) ndone++;
    tick();
    if (bus.done_o) ndone++;
    tick();
    if (bus.done_o) ndone++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done_o) ndone++;
      tick();
    end
    chk("abort done count", ndone, 0);
    chk("abort busy", bus.busy_o, 0);
    chk("abort spike", bus.spike_o, 0);
    chk_state("abort", -650, -650, -650, -650, -130, -130, -130, -130);

    // rst and step together: rst wins
    ndone = 0;
    rst = 1'b1;
    bus.step_i = 1'b1;
    tick();
    rst = 1'b0;
    bus.step_i = 1'b0;
    chk("rst+step busy", bus.busy_o, 0);
    for (int c = 0; c < 8; c++) begin
      if (bus.done_o || bus.busy_o) ndone++;
      tick();
    end
    chk("rst+step activity", ndone, 0);
    chk_state("rst+step", -650, -650, -650, -650, -130, -130, -130, -130);
    bus.i_in = '0;

`ifdef IZH_SPIKE_COUNT_EN
    bus.i_in   = pack(0, 0, 1023, 0);
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    lat = 1;
    while (!bus.done_o && lat < 20) begin
      tick();
      lat++;
    end
    chk("cnt done latency", lat, N + 1);
    tick();
    bus.rd_idx = 2'd2;
    #0.1;
    chk("cnt neuron2", bus.rd_cnt, 1);
    bus.rd_idx = 2'd0;
    #0.1;
    chk("cnt neuron0", bus.rd_cnt, 0);
    bus.clr_cnt_i = 1'b1;
    tick();
    bus.clr_cnt_i = 1'b0;
    bus.rd_idx = 2'd2;
    #0.1;
    chk("cnt cleared", bus.rd_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
